// File: rtl/demod_lo_ctrl.sv
// Burst sequencer and fs/4 quadrature LO generator for the IQ demodulator.
// Qualifies ADC samples, steps the LO phase and reports burst completion.
module demod_lo_ctrl #(
  parameter int SAMPLES_PER_BURST = 256,
  parameter int DIV = 1,
  localparam int CW = $clog2(SAMPLES_PER_BURST + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              ADC_rdy,
  input  logic [1:0]        phase_init,
  input  logic              dir,
  output logic signed [1:0] cosine_out,
  output logic signed [1:0] sine_out,
  output logic              demod_en,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     sample_cnt
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      phase;
  logic            dir_q;
  logic [DW-1:0]   div_cnt;
  logic            launch;
  logic            accept;
  logic            last_smp;

  assign launch   = (state_q == IDLE) && start && !abort;
  assign accept   = (state_q == RUN) && ADC_rdy && !abort;
  assign last_smp = accept && (sample_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = RUN;
      RUN: begin
        if (abort)         state_d = IDLE;
        else if (last_smp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase      <= '0;
      dir_q      <= 1'b0;
      div_cnt    <= '0;
      sample_cnt <= '0;
      demod_en   <= 1'b0;
    end else begin
      demod_en <= accept;
      if (launch) begin
        phase      <= phase_init;
        dir_q      <= dir;
        div_cnt    <= '0;
        sample_cnt <= '0;
      end else if (accept) begin
        sample_cnt <= sample_cnt + 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          phase   <= phase + 2'd1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // LO is forced to zero outside RUN so the demod output is quiet.
  always_comb begin
    cosine_out = '0;
    sine_out   = '0;
    if (busy) begin
      unique case (phase)
        2'd0: cosine_out = 2'sd1;
        2'd1: sine_out   = 2'sd1;
        2'd2: cosine_out = -2'sd1;
        2'd3: sine_out   = -2'sd1;
        default: ;
      endcase
      if (dir_q) sine_out = -sine_out;
    end
  end

endmodule

// File: tb/tb_demod_lo_ctrl.sv
// Scoreboard bench for demod_lo_ctrl: three instances cover
// the basic/direction burst, the LO divider and back-to-back bursts.
module tb_demod_lo_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ADC_rdy = 1'b0;
  logic [1:0] phase_init = 2'd0;
  logic       dir = 1'b0;

  logic [1:0] cos_o [3];
  logic [1:0] sin_o [3];
  logic       den_o [3];
  logic       bsy_o [3];
  logic       dn_o  [3];
  logic [3:0] cnt_o [3];
  logic [3:0] c0;
  logic [3:0] c1;
  logic [2:0] c2;

  assign cnt_o[0] = c0;
  assign cnt_o[1] = c1;
  assign cnt_o[2] = {1'b0, c2};

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  demod_lo_ctrl #(.SAMPLES_PER_BURST(8), .DIV(1)) dut0 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .ADC_rdy(ADC_rdy), .phase_init(phase_init), .dir(dir),
    .cosine_out(cos_o[0]), .sine_out(sin_o[0]), .demod_en(den_o[0]),
    .busy(bsy_o[0]), .done(dn_o[0]), .sample_cnt(c0)
  );

  demod_lo_ctrl #(.SAMPLES_PER_BURST(8), .DIV(2)) dut1 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .ADC_rdy(ADC_rdy), .phase_init(phase_init), .dir(dir),
    .cosine_out(cos_o[1]), .sine_out(sin_o[1]), .demod_en(den_o[1]),
    .busy(bsy_o[1]), .done(dn_o[1]), .sample_cnt(c1)
  );

  demod_lo_ctrl #(.SAMPLES_PER_BURST(4), .DIV(1)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .ADC_rdy(ADC_rdy), .phase_init(phase_init), .dir(dir),
    .cosine_out(cos_o[2]), .sine_out(sin_o[2]), .demod_en(den_o[2]),
    .busy(bsy_o[2]), .done(dn_o[2]), .sample_cnt(c2)
  );

  // Expected {cos, sin} for a phase index and direction.
  function automatic logic [3:0] lo(input logic [1:0] p, input logic d);
    logic [1:0] c;
    logic [1:0] s;
    c = 2'b00;
    s = 2'b00;
    if (p == 2'd0) c = 2'b01;
    if (p == 2'd1) s = 2'b01;
    if (p == 2'd2) c = 2'b11;
    if (p == 2'd3) s = 2'b11;
    if (d && s == 2'b01) s = 2'b11;
    else if (d && s == 2'b11) s = 2'b01;
    return {c, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ADC_rdy = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic run_burst(input int d, input int spb, input int div,
                           input logic [1:0] pi, input logic dr,
                           input int gap, input bit start_in_done);
    logic [1:0] p;
    logic [3:0] e;
    int dc;
    int n;
    int cyc;
    bit adc;
    bit prev;
    p = pi;
    dc = 0;
    n = 0;
    cyc = 0;
    prev = 1'b0;
    start = 1'b1;
    phase_init = pi;
    dir = dr;
    step();
    start = 1'b0;
    phase_init = pi + 2'd1;
    dir = ~dr;
    while (n < spb) begin
      adc = ((cyc % gap) == gap - 1);
      ADC_rdy = adc;
      if (adc) begin
        exp_q.push_back(lo(p, dr));
        n++;
        if (dc == div - 1) begin
          dc = 0;
          p = p + 2'd1;
        end else begin
          dc++;
        end
      end
      smp();
      if (cyc == 0) begin
        checks++;
        if (cnt_o[d] !== 4'd0 || {cos_o[d], sin_o[d]} !== lo(pi, dr)) begin
          failures++;
          $display("FAIL burst_start d=%0d cnt=%0d lo=%h exp cnt=0 lo=%h",
                   d, cnt_o[d], {cos_o[d], sin_o[d]}, lo(pi, dr));
        end
      end
      checks++;
      if (bsy_o[d] !== 1'b1 || dn_o[d] !== 1'b0 || den_o[d] !== prev) begin
        failures++;
        $display("FAIL run_flags d=%0d cyc=%0d busy=%b done=%b den=%b exp 1 0 %b",
                 d, cyc, bsy_o[d], dn_o[d], den_o[d], prev);
      end
      if (adc) begin
        e = exp_q.pop_front();
        checks++;
        if ({cos_o[d], sin_o[d]} !== e) begin
          failures++;
          $display("FAIL lo_value d=%0d sample=%0d got=%h exp=%h",
                   d, n, {cos_o[d], sin_o[d]}, e);
        end
      end
      prev = adc;
      step();
      cyc++;
    end
    ADC_rdy = 1'b0;
    if (start_in_done) start = 1'b1;
    smp();
    checks++;
    if (dn_o[d] !== 1'b1 || den_o[d] !== 1'b1 || bsy_o[d] !== 1'b0 ||
        cnt_o[d] !== 4'(spb) || {cos_o[d], sin_o[d]} !== 4'h0) begin
      failures++;
      $display("FAIL done_cycle d=%0d done=%b den=%b busy=%b cnt=%0d lo=%h exp 1 1 0 %0d 0",
               d, dn_o[d], den_o[d], bsy_o[d], cnt_o[d], {cos_o[d], sin_o[d]}, spb);
    end
    step();
    start = 1'b0;
    smp();
    checks++;
    if (dn_o[d] !== 1'b0 || bsy_o[d] !== 1'b0 || den_o[d] !== 1'b0 ||
        cnt_o[d] !== 4'(spb)) begin
      failures++;
      $display("FAIL after_done d=%0d done=%b busy=%b den=%b cnt=%0d exp 0 0 0 %0d",
               d, dn_o[d], bsy_o[d], den_o[d], cnt_o[d], spb);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left d=%0d got=%0d exp=0", d, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({cos_o[d], sin_o[d], den_o[d], bsy_o[d], dn_o[d], cnt_o[d]} !== 11'd0) begin
        failures++;
        $display("FAIL reset_state d=%0d got=%h exp=0", d,
                 {cos_o[d], sin_o[d], den_o[d], bsy_o[d], dn_o[d], cnt_o[d]});
      end
    end
    step();
    start = 1'b1;
    phase_init = 2'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ADC_rdy = ~ADC_rdy;
      step();
    end
    ADC_rdy = 1'b1;
    step();
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({cos_o[d], sin_o[d], den_o[d], bsy_o[d], dn_o[d], cnt_o[d]} !== 11'd0) begin
        failures++;
        $display("FAIL async_reset d=%0d got=%h exp=0", d,
                 {cos_o[d], sin_o[d], den_o[d], bsy_o[d], dn_o[d], cnt_o[d]});
      end
    end
    step();
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ADC_rdy = ~ADC_rdy;
      smp();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({cos_o[d], sin_o[d], den_o[d], bsy_o[d], dn_o[d], cnt_o[d]} !== 11'd0) begin
          failures++;
          $display("FAIL idle_after_reset d=%0d cyc=%0d got=%h exp=0", d, i,
                   {cos_o[d], sin_o[d], den_o[d], bsy_o[d], dn_o[d], cnt_o[d]});
        end
      end
      step();
    end
    ADC_rdy = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    run_burst(0, 8, 1, 2'd0, 1'b0, 3, 1'b0);
  endtask

  task automatic test_dir_phase();
    do_reset();
    run_burst(0, 8, 1, 2'd1, 1'b1, 2, 1'b0);
  endtask

  task automatic test_divider();
    do_reset();
    run_burst(1, 8, 2, 2'd0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_abort();
    logic [1:0] p;
    logic [3:0] e;
    bit adc;
    do_reset();
    p = 2'd2;
    start = 1'b1;
    phase_init = 2'd2;
    dir = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adc = (i % 2 == 1);
      ADC_rdy = adc;
      start = (i == 2);
      phase_init = 2'd0;
      if (adc) begin
        exp_q.push_back(lo(p, 1'b0));
        p = p + 2'd1;
      end
      smp();
      if (adc) begin
        e = exp_q.pop_front();
        checks++;
        if ({cos_o[0], sin_o[0]} !== e) begin
          failures++;
          $display("FAIL abort_lo cyc=%0d got=%h exp=%h", i, {cos_o[0], sin_o[0]}, e);
        end
      end
      step();
    end
    start = 1'b0;
    ADC_rdy = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    ADC_rdy = 1'b0;
    smp();
    checks++;
    if (bsy_o[0] !== 1'b0 || dn_o[0] !== 1'b0 || den_o[0] !== 1'b0 ||
        cnt_o[0] !== 4'd3 || {cos_o[0], sin_o[0]} !== 4'h0) begin
      failures++;
      $display("FAIL abort_state busy=%b done=%b den=%b cnt=%0d lo=%h exp 0 0 0 3 0",
               bsy_o[0], dn_o[0], den_o[0], cnt_o[0], {cos_o[0], sin_o[0]});
    end
    step();
    smp();
    checks++;
    if (dn_o[0] !== 1'b0 || cnt_o[0] !== 4'd3) begin
      failures++;
      $display("FAIL abort_hold done=%b cnt=%0d exp 0 3", dn_o[0], cnt_o[0]);
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    smp();
    checks++;
    if (bsy_o[0] !== 1'b0 || cnt_o[0] !== 4'd3) begin
      failures++;
      $display("FAIL start_abort_idle busy=%b cnt=%0d exp 0 3", bsy_o[0], cnt_o[0]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_burst(2, 4, 1, 2'd2, 1'b0, 1, 1'b1);
    run_burst(2, 4, 1, 2'd3, 1'b1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dir_phase();
    test_divider();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demod_lo_ctrl.md
# demod_lo_ctrl

Burst sequencer and local-oscillator generator for the IQ demodulation datapath. It produces the 2-bit signed quadrature LO pair (cosine/sine, fs/4 rotation) stepped on each accepted ADC sample. It qualifies samples into the demodulator, counts a burst of samples, and reports completion. It sits between the ADC sample strobe and the demodulator's sine_in/cosine_in inputs.

## Interface
- SAMPLES_PER_BURST, 256: accepted samples per burst; must be ≥1.
- DIV, 1: accepted samples per LO phase step; must be ≥1.
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begins a burst; sampled only in IDLE.
- abort  in  1  ends the burst immediately; no done pulse.
- ADC_rdy  in  1  sample strobe; one sample per clk cycle while high.
- phase_init  in  2  LO phase index loaded at start (0..3).
- dir  in  1  0: sine as tabulated; 1: sine negated (image select).
- cosine_out  out  2 signed  LO cosine to the demodulator.
- sine_out  out  2 signed  LO sine to the demodulator.
- demod_en  out  1  registered one-cycle pulse per accepted sample.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at burst completion.
- sample_cnt  out  $clog2(SAMPLES_PER_BURST+1)  samples accepted in the current or last burst.

## Operation
- The phase table (index: cos, sin) is 0: 1, 0; 1: 0, 1; 2: -1, 0; 3: 0, -1. With dir=1, sine is negated. The value -2 is never driven.
- **IDLE**: cos=sin=0, so the demod output is zero, and busy=0. start=1 with abort=0 moves to RUN. At that edge the block loads phase=phase_init, latches dir, and clears sample_cnt and the divide counter.
- **RUN**: cos/sin = table[phase], registered. An edge with ADC_rdy=1 is an accepted sample:
  - sample_cnt increments.
  - the divide counter increments. When it reaches DIV-1, it clears and phase advances by 1 mod 4 (3 wraps to 0).
  - demod_en=1 in the following cycle.
- When the accepted sample makes sample_cnt=SAMPLES_PER_BURST, the state moves to DONE.
- **DONE**: lasts one cycle. done=1, busy=0, cos=sin=0. The next state is IDLE. ADC_rdy is ignored.
- abort=1 in RUN or DONE moves to IDLE at the next edge.
  - No done pulse is produced. sample_cnt holds its value.
  - Any sample accepted on that same edge is not counted.
  - abort has priority over start and over burst completion in the same cycle.
- start in RUN or DONE is ignored. ADC_rdy in IDLE is ignored.
- sample_cnt holds its final value until the next start.
- phase_init and dir are sampled only at start. Changes during RUN have no effect.

## Timing
- Reset: state=IDLE; cosine_out=0, sine_out=0, demod_en=0, busy=0, done=0, sample_cnt=0; phase and divide counter=0.
- start accepted at edge t: busy=1 and cos/sin=table[phase_init] are visible from t.
- The LO value applied to a sample is the value present during the cycle its ADC_rdy is high. The advanced phase is visible from the accepting edge onward.
- demod_en lags the accepting edge by exactly one cycle. The final sample's demod_en pulse coincides with done.
- With ADC_rdy held high from the cycle after start, done rises exactly SAMPLES_PER_BURST edges after start.
- Minimum burst-to-burst spacing is one IDLE cycle. start asserted during DONE is ignored.
- Asynchronous reset mid-burst forces all reset values immediately, without waiting for an edge.

## Test plan
- **Reset**: assert resetn=0 mid-RUN with ADC_rdy toggling → all outputs 0 immediately. After release with no start, outputs stay 0.
- **Basic burst**: SAMPLES_PER_BURST=8, DIV=1, phase_init=0, dir=0, ADC_rdy one cycle in three.
  - Per-sample (cos, sin) is (1,0), (0,1), (-1,0), (0,-1), repeated twice.
  - done pulses one cycle after the 8th accepting edge, with sample_cnt=8.
  - 8 demod_en pulses, each one cycle after its ADC_rdy.
- **Direction and initial phase**: dir=1, phase_init=1 → sin sequence -1, 0, 1, 0, …; cos sequence 0, -1, 0, 1, …
- **Divider**: DIV=2 → each LO value spans 2 accepted samples: (1,0), (1,0), (0,1), (0,1), …
- **Abort**: abort after the 3rd accepted sample.
  - Next cycle: busy=0, cos=sin=0, no done, sample_cnt=3.
  - start pulsed during RUN earlier has no effect.
  - start and abort asserted together in IDLE → block remains in IDLE.
- **Back-to-back**: ADC_rdy continuously high, SAMPLES_PER_BURST=4 → done exactly 4 edges after start.
  - A start pulse during DONE is ignored.
  - A start in the following IDLE cycle begins a new burst, and sample_cnt clears to 0.
